// File: rtl/seq_det_moore.sv
// Moore serial detector for PATTERN (KMP failure transitions), registered detect, saturating det_count; SEQ_DET_OVERLAP_EN selects overlapping matches.
// Latency: detect rises the cycle after the final pattern bit's edge; one bit per clock, no backpressure (din_valid=0 holds all state).
module seq_det_moore #(
    parameter logic [7:0] PATTERN = 8'b0000_1011,
    parameter int         PAT_LEN = 4,
    parameter int         CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             din_valid,
    input  logic             cnt_clr,
    output logic             detect,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] det_count
);

    if (PAT_LEN < 1 || PAT_LEN > 8) begin : g_bad_pat_len
        $error("seq_det_moore: PAT_LEN=%0d outside legal range 1..8", PAT_LEN);
    end

    localparam int PL = (PAT_LEN < 1) ? 1 : ((PAT_LEN > 8) ? 8 : PAT_LEN);

`ifdef SEQ_DET_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    typedef enum logic [3:0] {
        S0 = 4'd0, S1 = 4'd1, S2 = 4'd2, S3 = 4'd3, S4 = 4'd4,
        S5 = 4'd5, S6 = 4'd6, S7 = 4'd7, S8 = 4'd8
    } state_t;

    // Longest pattern prefix that is a suffix of (matched prefix, b), per state.
    function automatic logic [15:0][3:0] build_next(input logic b);
        logic [15:0][3:0] t;
        logic [8:0]       s;
        logic             ok;
        int               kk;
        int               best;
        t = '0;
        for (int k = 0; k <= PL; k++) begin
            kk = (k == PL) ? (OVERLAP ? PL : 0) : k;
            s  = '0;
            for (int i = 0; i < kk; i++) s[i] = PATTERN[PL-1-i];
            s[kk] = b;
            best = 0;
            for (int j = 1; j <= PL; j++) begin
                if (j <= kk + 1) begin
                    ok = 1'b1;
                    for (int i = 0; i < j; i++)
                        if (s[kk+1-j+i] != PATTERN[PL-1-i]) ok = 1'b0;
                    if (ok) best = j;
                end
            end
            t[k] = 4'(best);
        end
        return t;
    endfunction

    localparam logic [15:0][3:0] NXT0    = build_next(1'b0);
    localparam logic [15:0][3:0] NXT1    = build_next(1'b1);
    localparam logic [3:0]       PL4     = 4'(PL);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state_q;
    state_t nxt;

    always_comb begin
        nxt = state_q;
        if (din) nxt = state_t'(NXT1[state_q]);
        else     nxt = state_t'(NXT0[state_q]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S0;
            detect    <= 1'b0;
            det_count <= '0;
        end else begin
            if (din_valid) begin
                state_q <= nxt;
                detect  <= (nxt == PL4);
            end
            // Clear has priority over a coincident detection.
            if (cnt_clr)
                det_count <= '0;
            else if (din_valid && nxt == PL4 && det_count != CNT_MAX)
                det_count <= det_count + 1'b1;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_seq_det_moore.sv
// Directed bench for seq_det_moore (PATTERN=1011, PAT_LEN=4, CNT_W=2); expectations follow SEQ_DET_OVERLAP_EN.
module tb_seq_det_moore;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_valid;
    logic       cnt_clr;
    logic       detect;
    logic [3:0] state;
    logic [1:0] det_count;

    int total  = 0;
    int passed = 0;

    seq_det_moore #(
        .PATTERN (8'b0000_1011),
        .PAT_LEN (4),
        .CNT_W   (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .cnt_clr   (cnt_clr),
        .detect    (detect),
        .state     (state),
        .det_count (det_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Drive one cycle, then check state and the Moore detect flag after the edge.
    task automatic vec(input string tag, input logic b, input logic v, input logic clr,
                       input logic [3:0] exp_state);
        din       = b;
        din_valid = v;
        cnt_clr   = clr;
        @(posedge clk);
        #1;
        chk({tag, ".state"}, 32'(state), 32'(exp_state));
        chk({tag, ".detect"}, 32'(detect), 32'(exp_state == 4'd4));
    endtask

    logic       sa [7] = '{1, 0, 1, 1, 0, 1, 1};
`ifdef SEQ_DET_OVERLAP_EN
    logic [3:0] ea [7] = '{1, 2, 3, 4, 2, 3, 4};
    logic [1:0] ca     = 2'd2;
`else
    logic [3:0] ea [7] = '{1, 2, 3, 4, 0, 1, 1};
    logic [1:0] ca     = 2'd1;
`endif
    logic       fa [5] = '{1, 1, 0, 1, 1};
    logic [3:0] fe [5] = '{1, 1, 2, 3, 4};
    logic       fb [6] = '{1, 0, 1, 0, 1, 1};
    logic [3:0] fx [6] = '{1, 2, 3, 2, 3, 4};
    logic       pb [4] = '{1, 0, 1, 1};
    logic [3:0] px [4] = '{1, 2, 3, 4};

    initial begin
        rst       = 1'b0;
        din       = 1'b0;
        din_valid = 1'b0;
        cnt_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.state", 32'(state), 0);
        chk("reset.detect", 32'(detect), 0);
        chk("reset.count", 32'(det_count), 0);
        rst = 1'b1;

        // Stream 1,0,1,1,0,1,1
        for (int i = 0; i < 7; i++) vec("stream", sa[i], 1'b1, 1'b0, ea[i]);
        chk("stream.count", 32'(det_count), 32'(ca));

        // 1,0,1 reaches S3 from either end state, then async reset between edges
        vec("prerst", 1'b1, 1'b1, 1'b0, 4'd1);
        vec("prerst", 1'b0, 1'b1, 1'b0, 4'd2);
        vec("prerst", 1'b1, 1'b1, 1'b0, 4'd3);
        #2 rst = 1'b0;
        #2;
        chk("async_rst.state", 32'(state), 0);
        chk("async_rst.detect", 32'(detect), 0);
        chk("async_rst.count", 32'(det_count), 0);
        #1 rst = 1'b1;
        vec("postrst", 1'b1, 1'b1, 1'b0, 4'd1);
        vec("postrst", 1'b1, 1'b1, 1'b0, 4'd1);

        // Stalls: din toggles while invalid and must be ignored
        vec("stall_pre", 1'b1, 1'b1, 1'b0, 4'd1);
        vec("stall_pre", 1'b0, 1'b1, 1'b0, 4'd2);
        vec("stall_pre", 1'b1, 1'b1, 1'b0, 4'd3);
        for (int i = 0; i < 5; i++) vec("stall", i[0], 1'b0, 1'b0, 4'd3);
        vec("stall_hit", 1'b1, 1'b1, 1'b0, 4'd4);
        chk("stall_hit.count", 32'(det_count), 1);
        for (int i = 0; i < 3; i++) vec("stall_hold", i[0], 1'b0, 1'b0, 4'd4);

        // Failure transitions; both start from S4 where 1 -> S1 in either mode
        for (int i = 0; i < 5; i++) vec("fail_a", fa[i], 1'b1, 1'b0, fe[i]);
        chk("fail_a.count", 32'(det_count), 2);
        for (int i = 0; i < 6; i++) vec("fail_b", fb[i], 1'b1, 1'b0, fx[i]);
        chk("fail_b.count", 32'(det_count), 3);

        // Two more detections: counter saturates at 3
        for (int i = 0; i < 4; i++) vec("sat4", pb[i], 1'b1, 1'b0, px[i]);
        chk("sat4.count", 32'(det_count), 3);
        for (int i = 0; i < 4; i++) vec("sat5", pb[i], 1'b1, 1'b0, px[i]);
        chk("sat5.count", 32'(det_count), 3);

        // Clear coincident with a detection: clear wins
        for (int i = 0; i < 3; i++) vec("clr_pre", pb[i], 1'b1, 1'b0, px[i]);
        vec("clr_hit", 1'b1, 1'b1, 1'b1, 4'd4);
        chk("clr_hit.count", 32'(det_count), 0);
        vec("clr_after", 1'b0, 1'b0, 1'b0, 4'd4);
        chk("clr_after.count", 32'(det_count), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/seq_det_moore.md
# seq_det_moore

Moore-style serial sequence detector for the sequence-detector datapath. It samples one bit per qualified clock, tracks how many leading pattern bits are currently matched, and raises a registered `detect` flag while the full pattern is matched. It also keeps a saturating count of detections. The block is the state-register stage built on the team's asynchronous active-low flip-flop convention, and it feeds the downstream display/result logic.

## Interface
Parameters:
- `PATTERN`, default `8'b0000_1011`: target sequence, right-aligned. The MSB of the used field is the first bit received.
- `PAT_LEN`, default `4`: number of valid bits in `PATTERN`, legal range 1..8.
- `CNT_W`, default `8`: width of the detection counter.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `din` input 1: serial data bit.
- `din_valid` input 1: `din` is sampled only when this is 1.
- `cnt_clr` input 1: synchronous clear of `det_count`.
- `detect` output 1: Moore output, 1 exactly while state = S`PAT_LEN`.
- `state` output 4: current state index, 0..`PAT_LEN` (debug).
- `det_count` output `CNT_W`: number of entries into S`PAT_LEN`, saturating.

## Operation
States and outputs:
- States S0..S`PAT_LEN`. Sk means the last k sampled bits equal the first k pattern bits.
- Sk is the longest such match.
- All outputs are registered or decoded from the state register only. There is no combinational path from `din` to any output.

Next-state rule, applied when `din_valid`=1:
- From Sk with k<`PAT_LEN`: the next state is the longest j such that (matched prefix k, followed by `din`) ends with pattern prefix j. This is the KMP failure transition; it is not simply S0 on a mismatch.
- For 1011, the transitions are:
  - S0: 1→S1, 0→S0
  - S1: 0→S2, 1→S1
  - S2: 1→S3, 0→S0
  - S3: 1→S4, 0→S2
- Transitions out of S`PAT_LEN` depend on the configuration (see Configuration).
- When `din_valid`=0, the state holds and `detect` holds.

`det_count`:
- Increments by 1 on every qualified transition into S`PAT_LEN`, including S`PAT_LEN`→S`PAT_LEN` when `PAT_LEN`=1.
- Saturates at all-ones and never wraps.
- `cnt_clr`=1 forces 0 on the next edge.
- If `cnt_clr` and a detection occur in the same cycle, the clear wins and the result is 0.

Reset:
- `rst`=0, at any time including mid-pattern, immediately forces `state`=0, `detect`=0 and `det_count`=0, without waiting for a clock edge.
- Bits sampled before the reset are discarded.
- Release must be synchronous to `clk`, which is the integrator's responsibility.
- The first bit is sampled on the first rising edge with `rst`=1 and `din_valid`=1.

Illegal parameters: `PAT_LEN` outside 1..8 is a configuration error. Simulation must report it with `$error` at elaboration.

## Timing
- Latency: the final pattern bit is sampled on edge N, and `detect`=1 during the cycle after edge N.
- `detect` remains 1 until the next qualified sample moves the state out of S`PAT_LEN`.
- With continuous `din_valid`, `detect` is a one-cycle pulse, except when a run of repeated matches occurs (such as `PAT_LEN`=1).
- `det_count` updates on the same edge that `detect` rises.
- Throughput: one bit per clock. There are no stall cycles.

## Configuration
Macro `SEQ_DET_OVERLAP_EN`:
- **Defined (overlapping detection):** from S`PAT_LEN`, the transition uses the same failure rule with k=`PAT_LEN`. The matched suffix is retained; for 1011, the detect state continues as 1→S1 and 0→S2.
- **Undefined (non-overlapping detection):** S`PAT_LEN` behaves exactly like S0 for the next sampled bit. For 1011, the detect state continues as 1→S1 and 0→S0.
- The macro has no effect on ports, reset or counter behaviour.

## Test plan
All scenarios use the defaults: `PATTERN`=1011, `PAT_LEN`=4.
- **Overlapping stream:** with `SEQ_DET_OVERLAP_EN` defined and `din_valid`=1, feed 1,0,1,1,0,1,1 → `detect` pulses after the 4th and the 7th edges, and `det_count`=2.
- **Non-overlapping stream:** same stream with the macro undefined → a single pulse after the 4th edge, and `det_count`=1.
- **Stalls:** feed 1,0,1 then `din_valid`=0 for 5 cycles, then 1 → `state` holds at 3 during the stall. `detect` rises after the valid 1 and stays high while `din_valid` stays 0.
- **Reset mid-pattern:** feed 1,0,1, then pulse `rst` low between edges → `state`, `detect` and `det_count` go to 0 with no clock edge. Then 1,1 → no detect, `state`=1.
- **Counter:** with `CNT_W`=2, produce 5 detections → `det_count` reads 1,2,3,3,3. Assert `cnt_clr` on the same edge as a detection → `det_count`=0 while `detect`=1.
- **Failure transitions:** 1,1,0,1,1 → states 1,1,2,3,4 and one detection. 1,0,1,0,1,1 → states 1,2,3,2,3,4.
